// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for a 5-stage in-order core.
//
// Resolves data hazards by forwarding from EX/MEM, stalls on load-use,
// flushes on taken branches, and freezes the pipe while a multi-cycle
// mul/div unit (MDU) is busy, with a timeout that raises a sticky error.
//
// Parameters
//   LOAD_STALL_CYC  stall cycles per load-use hazard (1..3)
//   MDU_TIMEOUT     max cycles to wait for MDU_done (2..255)
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   ID_rs1/ID_rs2 [4:0]         source registers of the ID instruction
//   ID_rs1_used/ID_rs2_used     ID instruction actually reads the source
//   ID_vld                      ID holds a valid instruction
//   EX_rd, EX_x_rd_vld, EX_is_load   EX destination, write enable, load flag
//   MEM_rd, MEM_x_rd_vld        MEM destination, write enable
//   EX_br_taken                 branch/jump taken in EX this cycle
//   EX_mdu_start                MDU launch pulse
//   MDU_done                    MDU result ready pulse
//   HC_fwd_sel1/2 [1:0]         0=regfile, 1=EX result, 2=MEM result
//   HC_stall_if/id/ex           hold PC, IF-ID, ID-EX
//   HC_bubble_ex                load NOP into ID-EX
//   HC_flush_id                 replace IF-ID with NOP
//   HC_mdu_err                  sticky MDU timeout flag
//   HC_stall_cnt [15:0]         saturating count of ID stall cycles
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | normal flow; single-cycle load-use stall handled here
// LD_STALL | extra load-use stall cycles, counted down by ld_cnt_q
// MDU_BUSY | pipe frozen waiting for MDU_done or timeout
// FLUSH    | second cycle of a taken-branch flush (IF-ID only)

module hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYC = 1,
    parameter int unsigned MDU_TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic        ID_rs1_used,
    input  logic        ID_rs2_used,
    input  logic        ID_vld,
    input  logic [4:0]  EX_rd,
    input  logic        EX_x_rd_vld,
    input  logic        EX_is_load,
    input  logic [4:0]  MEM_rd,
    input  logic        MEM_x_rd_vld,
    input  logic        EX_br_taken,
    input  logic        EX_mdu_start,
    input  logic        MDU_done,
    output logic [1:0]  HC_fwd_sel1,
    output logic [1:0]  HC_fwd_sel2,
    output logic        HC_stall_if,
    output logic        HC_stall_id,
    output logic        HC_stall_ex,
    output logic        HC_bubble_ex,
    output logic        HC_flush_id,
    output logic        HC_mdu_err,
    output logic [15:0] HC_stall_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LD_STALL = 2'd1,
        MDU_BUSY = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam logic [1:0] LD_INIT   = 2'(LOAD_STALL_CYC - 1);
    localparam bit         LD_MULTI  = (LOAD_STALL_CYC > 1);
    localparam logic [7:0] MDU_LIMIT = 8'(MDU_TIMEOUT);

    state_t      state_q, state_d;
    logic [1:0]  ld_cnt_q, ld_cnt_d;
    logic [7:0]  mdu_cnt_q, mdu_cnt_d;
    logic        mdu_err_q;
    logic        mdu_timeout;
    logic [15:0] stall_cnt_q;
    logic        load_use;

    // A load in EX cannot forward (data not yet available), so it is
    // skipped here and the older MEM value is used; the load-use stall
    // covers the dependency.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] ex_rd,
        input logic       ex_vld,
        input logic       ex_ld,
        input logic [4:0] mem_rd,
        input logic       mem_vld
    );
        if (ex_vld && (ex_rd == rs) && (ex_rd != 5'd0) && !ex_ld)
            return 2'd1;
        else if (mem_vld && (mem_rd == rs) && (mem_rd != 5'd0))
            return 2'd2;
        else
            return 2'd0;
    endfunction

    assign HC_fwd_sel1 = fwd_sel(ID_rs1, EX_rd, EX_x_rd_vld, EX_is_load,
                                 MEM_rd, MEM_x_rd_vld);
    assign HC_fwd_sel2 = fwd_sel(ID_rs2, EX_rd, EX_x_rd_vld, EX_is_load,
                                 MEM_rd, MEM_x_rd_vld);

    assign load_use = ID_vld && EX_is_load && EX_x_rd_vld && (EX_rd != 5'd0) &&
                      ((ID_rs1_used && (EX_rd == ID_rs1)) ||
                       (ID_rs2_used && (EX_rd == ID_rs2)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ld_cnt_q    <= 2'd0;
            mdu_cnt_q   <= 8'd0;
            mdu_err_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            ld_cnt_q  <= ld_cnt_d;
            mdu_cnt_q <= mdu_cnt_d;
            if (mdu_timeout)
                mdu_err_q <= 1'b1;
            if (HC_stall_id && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        ld_cnt_d     = ld_cnt_q;
        mdu_cnt_d    = mdu_cnt_q;
        mdu_timeout  = 1'b0;
        HC_stall_if  = 1'b0;
        HC_stall_id  = 1'b0;
        HC_stall_ex  = 1'b0;
        HC_bubble_ex = 1'b0;
        HC_flush_id  = 1'b0;

        case (state_q)
            IDLE: begin
                if (EX_br_taken) begin
                    HC_flush_id  = 1'b1;
                    HC_bubble_ex = 1'b1;
                    state_d      = FLUSH;
                end else if (EX_mdu_start) begin
                    mdu_cnt_d = 8'd0;
                    state_d   = MDU_BUSY;
                end else if (load_use) begin
                    HC_stall_if  = 1'b1;
                    HC_stall_id  = 1'b1;
                    HC_bubble_ex = 1'b1;
                    if (LD_MULTI) begin
                        ld_cnt_d = LD_INIT;
                        state_d  = LD_STALL;
                    end
                end
            end

            LD_STALL: begin
                if (EX_br_taken) begin
                    HC_flush_id  = 1'b1;
                    HC_bubble_ex = 1'b1;
                    ld_cnt_d     = 2'd0;
                    state_d      = FLUSH;
                end else begin
                    HC_stall_if  = 1'b1;
                    HC_stall_id  = 1'b1;
                    HC_bubble_ex = 1'b1;
                    if (ld_cnt_q <= 2'd1) begin
                        ld_cnt_d = 2'd0;
                        state_d  = IDLE;
                    end else begin
                        ld_cnt_d = ld_cnt_q - 2'd1;
                    end
                end
            end

            MDU_BUSY: begin
                // done wins over a timeout landing in the same cycle
                if (MDU_done) begin
                    state_d = IDLE;
                end else if (mdu_cnt_q == MDU_LIMIT) begin
                    mdu_timeout = 1'b1;
                    state_d     = IDLE;
                end else begin
                    HC_stall_if = 1'b1;
                    HC_stall_id = 1'b1;
                    HC_stall_ex = 1'b1;
                    mdu_cnt_d   = mdu_cnt_q + 8'd1;
                end
            end

            FLUSH: begin
                HC_flush_id = 1'b1;
                if (EX_br_taken) begin
                    HC_bubble_ex = 1'b1;
                    state_d      = FLUSH;
                end else begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign HC_mdu_err   = mdu_err_q;
    assign HC_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int LSC = 2;
    localparam int TO  = 64;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ID_rs1, ID_rs2, EX_rd, MEM_rd;
    logic        ID_rs1_used, ID_rs2_used, ID_vld;
    logic        EX_x_rd_vld, EX_is_load, MEM_x_rd_vld;
    logic        EX_br_taken, EX_mdu_start, MDU_done;
    logic [1:0]  HC_fwd_sel1, HC_fwd_sel2;
    logic        HC_stall_if, HC_stall_id, HC_stall_ex, HC_bubble_ex, HC_flush_id;
    logic        HC_mdu_err;
    logic [15:0] HC_stall_cnt;

    hazard_ctrl #(.LOAD_STALL_CYC(LSC), .MDU_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used), .ID_vld(ID_vld),
        .EX_rd(EX_rd), .EX_x_rd_vld(EX_x_rd_vld), .EX_is_load(EX_is_load),
        .MEM_rd(MEM_rd), .MEM_x_rd_vld(MEM_x_rd_vld),
        .EX_br_taken(EX_br_taken), .EX_mdu_start(EX_mdu_start), .MDU_done(MDU_done),
        .HC_fwd_sel1(HC_fwd_sel1), .HC_fwd_sel2(HC_fwd_sel2),
        .HC_stall_if(HC_stall_if), .HC_stall_id(HC_stall_id), .HC_stall_ex(HC_stall_ex),
        .HC_bubble_ex(HC_bubble_ex), .HC_flush_id(HC_flush_id),
        .HC_mdu_err(HC_mdu_err), .HC_stall_cnt(HC_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // {sel1, sel2, stall_if, stall_id, stall_ex, bubble_ex, flush_id, mdu_err, stall_cnt}
    logic [25:0] dut_vec;
    assign dut_vec = {HC_fwd_sel1, HC_fwd_sel2, HC_stall_if, HC_stall_id, HC_stall_ex,
                      HC_bubble_ex, HC_flush_id, HC_mdu_err, HC_stall_cnt};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_rs1_used = 1'b0; ID_rs2_used = 1'b0; ID_vld = 1'b0;
        EX_rd = 5'd0; EX_x_rd_vld = 1'b0; EX_is_load = 1'b0;
        MEM_rd = 5'd0; MEM_x_rd_vld = 1'b0;
        EX_br_taken = 1'b0; EX_mdu_start = 1'b0; MDU_done = 1'b0;
    endtask

    task automatic set_ld_use(input logic [4:0] rd, input logic [4:0] rs2);
        EX_rd = rd; EX_is_load = 1'b1; EX_x_rd_vld = 1'b1;
        ID_rs2 = rs2; ID_rs2_used = 1'b1; ID_vld = 1'b1;
    endtask

    // ---------------- behavioural reference model ----------------
    int m_ld_left;   // further load-use stall cycles still owed
    bit m_flush;     // a flush follow-up cycle is owed
    bit m_mdu;       // MDU operation outstanding
    int m_elapsed;   // stalled cycles spent waiting on the MDU
    bit m_err;
    int m_cnt;

    task automatic m_reset();
        m_ld_left = 0; m_flush = 0; m_mdu = 0; m_elapsed = 0; m_err = 0; m_cnt = 0;
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (EX_x_rd_vld && EX_rd == rs && EX_rd != 0 && !EX_is_load) return 2'd1;
        if (MEM_x_rd_vld && MEM_rd == rs && MEM_rd != 0) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic m_hazard();
        return ID_vld && EX_is_load && EX_x_rd_vld && EX_rd != 0 &&
               ((ID_rs1_used && EX_rd == ID_rs1) || (ID_rs2_used && EX_rd == ID_rs2));
    endfunction

    function automatic logic [25:0] m_expect();
        logic sif, sid, sex, bub, fl;
        sif = 0; sid = 0; sex = 0; bub = 0; fl = 0;
        if (m_mdu) begin
            if (!(MDU_done || m_elapsed == TO)) begin sif = 1; sid = 1; sex = 1; end
        end else if (EX_br_taken) begin
            fl = 1; bub = 1;
        end else if (m_flush) begin
            fl = 1;
        end else if (m_ld_left > 0) begin
            sif = 1; sid = 1; bub = 1;
        end else if (!EX_mdu_start && m_hazard()) begin
            sif = 1; sid = 1; bub = 1;
        end
        return {m_fwd(ID_rs1), m_fwd(ID_rs2), sif, sid, sex, bub, fl, m_err, 16'(m_cnt)};
    endfunction

    task automatic m_step(input logic [25:0] e);
        if (m_mdu) begin
            if (MDU_done) m_mdu = 0;
            else if (m_elapsed == TO) begin m_err = 1; m_mdu = 0; end
            else m_elapsed++;
        end else if (EX_br_taken) begin
            m_flush = 1; m_ld_left = 0;
        end else if (m_flush) begin
            m_flush = 0;
        end else if (m_ld_left > 0) begin
            m_ld_left--;
        end else if (EX_mdu_start) begin
            m_mdu = 1; m_elapsed = 0;
        end else if (m_hazard()) begin
            m_ld_left = LSC - 1;
        end
        if (e[20] && m_cnt < 65535) m_cnt++;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        m_reset();
    endtask

    // ---------------- combinational vector table ----------------
    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2, idv;
        logic [4:0] exrd;
        logic       exv, exld;
        logic [4:0] memrd;
        logic       memv, br, ms;
        logic [1:0] s1, s2;
        logic       st, bu, fl;
    } vec_t;

    function automatic vec_t mk(input int rs1, rs2, u1, u2, idv, exrd, exv, exld,
                                input int memrd, memv, br, ms, s1, s2, st, bu, fl);
        vec_t v;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = 1'(u1); v.u2 = 1'(u2); v.idv = 1'(idv);
        v.exrd = 5'(exrd); v.exv = 1'(exv); v.exld = 1'(exld);
        v.memrd = 5'(memrd); v.memv = 1'(memv); v.br = 1'(br); v.ms = 1'(ms);
        v.s1 = 2'(s1); v.s2 = 2'(s2); v.st = 1'(st); v.bu = 1'(bu); v.fl = 1'(fl);
        return v;
    endfunction

    vec_t tbl[14];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          rs1 rs2 u1 u2 idv exrd exv exld memrd memv br ms s1 s2 st bu fl
        tbl[0]  = mk(5, 9, 1, 1, 1, 5, 1, 0, 5, 1, 0, 0, 1, 0, 0, 0, 0);
        tbl[1]  = mk(9, 5, 1, 1, 1, 5, 1, 0, 5, 1, 0, 0, 0, 1, 0, 0, 0);
        tbl[2]  = mk(0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(5, 3, 1, 1, 1, 5, 1, 1, 5, 1, 0, 0, 2, 0, 1, 1, 0);
        tbl[4]  = mk(5, 5, 1, 1, 1, 5, 0, 0, 5, 1, 0, 0, 2, 2, 0, 0, 0);
        tbl[5]  = mk(6, 7, 1, 1, 1, 6, 1, 0, 7, 1, 0, 0, 1, 2, 0, 0, 0);
        tbl[6]  = mk(3, 7, 1, 1, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(3, 7, 1, 0, 1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 3, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(3, 7, 1, 1, 1, 7, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1);
        tbl[10] = mk(3, 7, 1, 1, 1, 7, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[11] = mk(7, 3, 1, 1, 1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(4, 4, 1, 1, 1, 4, 1, 0, 4, 1, 0, 0, 1, 1, 0, 0, 0);
        tbl[13] = mk(7, 1, 1, 1, 1, 7, 1, 1, 7, 0, 0, 0, 0, 0, 1, 1, 0);

        clear_in();
        rst_n = 1'b0;
        m_reset();
        #12;
        chk("reset_state", 32'(dut_vec), 32'(0));

        // Under reset the FSM sits in IDLE, so outputs are purely combinational.
        for (int i = 0; i < 14; i++) begin
            ID_rs1 = tbl[i].rs1; ID_rs2 = tbl[i].rs2;
            ID_rs1_used = tbl[i].u1; ID_rs2_used = tbl[i].u2; ID_vld = tbl[i].idv;
            EX_rd = tbl[i].exrd; EX_x_rd_vld = tbl[i].exv; EX_is_load = tbl[i].exld;
            MEM_rd = tbl[i].memrd; MEM_x_rd_vld = tbl[i].memv;
            EX_br_taken = tbl[i].br; EX_mdu_start = tbl[i].ms;
            #1;
            chk($sformatf("tbl%0d_fwd", i), 32'({HC_fwd_sel1, HC_fwd_sel2}),
                32'({tbl[i].s1, tbl[i].s2}));
            chk($sformatf("tbl%0d_ctl", i),
                32'({HC_stall_if, HC_stall_id, HC_stall_ex, HC_bubble_ex, HC_flush_id}),
                32'({tbl[i].st, tbl[i].st, 1'b0, tbl[i].bu, tbl[i].fl}));
            #4;
        end

        // Load-use with LOAD_STALL_CYC=2: two stall cycles then release.
        do_reset();
        set_ld_use(5'd7, 5'd7);
        #1 chk("ld_c0", 32'({HC_stall_if, HC_stall_id, HC_bubble_ex}), 32'(3'b111));
        tick();
        EX_rd = 5'd0; EX_is_load = 1'b0; EX_x_rd_vld = 1'b0;
        #1 chk("ld_c1", 32'({HC_stall_if, HC_stall_id, HC_bubble_ex}), 32'(3'b111));
        tick();
        #1 chk("ld_c2", 32'({HC_stall_if, HC_stall_id, HC_bubble_ex}), 32'(3'b000));
        chk("ld_cnt", 32'(HC_stall_cnt), 32'(2));

        // Branch beats load-use.
        do_reset();
        set_ld_use(5'd7, 5'd7);
        EX_br_taken = 1'b1;
        #1 chk("br_c0", 32'({HC_flush_id, HC_bubble_ex, HC_stall_if, HC_stall_id}), 32'(4'b1100));
        tick();
        clear_in();
        #1 chk("br_c1", 32'({HC_flush_id, HC_bubble_ex, HC_stall_if, HC_stall_id}), 32'(4'b1000));
        tick();
        #1 chk("br_c2", 32'({HC_flush_id, HC_bubble_ex, HC_stall_if, HC_stall_id}), 32'(4'b0000));

        // MDU finishing after 10 busy cycles.
        do_reset();
        EX_mdu_start = 1'b1;
        #1 chk("mdu_start", 32'({HC_stall_if, HC_stall_id, HC_stall_ex}), 32'(3'b000));
        tick();
        EX_mdu_start = 1'b0;
        EX_br_taken = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1 chk($sformatf("mdu_busy%0d", k),
                   32'({HC_stall_if, HC_stall_id, HC_stall_ex, HC_flush_id, HC_bubble_ex}),
                   32'(5'b11100));
            tick();
        end
        EX_br_taken = 1'b0;
        MDU_done = 1'b1;
        #1 chk("mdu_done", 32'({HC_stall_if, HC_stall_id, HC_stall_ex}), 32'(3'b000));
        tick();
        MDU_done = 1'b0;
        #1 chk("mdu_after", 32'({HC_stall_if, HC_stall_id, HC_stall_ex, HC_mdu_err}), 32'(4'b0000));
        chk("mdu_cnt", 32'(HC_stall_cnt), 32'(10));

        // MDU timeout: 64 stall cycles then drop, sticky error.
        do_reset();
        EX_mdu_start = 1'b1;
        tick();
        EX_mdu_start = 1'b0;
        for (int k = 0; k < TO; k++) begin
            #1 chk($sformatf("to_busy%0d", k), 32'({HC_stall_if, HC_stall_id, HC_stall_ex}), 32'(3'b111));
            tick();
        end
        #1 chk("to_drop", 32'({HC_stall_if, HC_stall_id, HC_stall_ex, HC_mdu_err}), 32'(4'b0000));
        tick();
        #1 chk("to_err", 32'({HC_stall_if, HC_stall_id, HC_stall_ex, HC_mdu_err}), 32'(4'b0001));
        chk("to_cnt", 32'(HC_stall_cnt), 32'(TO));
        MDU_done = 1'b1;
        repeat (5) tick();
        MDU_done = 1'b0;
        chk("to_sticky", 32'(HC_mdu_err), 32'(1));
        rst_n = 1'b0;
        #1 chk("to_clear", 32'(HC_mdu_err), 32'(0));
        rst_n = 1'b1;

        // Reset in the middle of MDU_BUSY takes effect immediately.
        do_reset();
        EX_mdu_start = 1'b1;
        tick();
        EX_mdu_start = 1'b0;
        tick();
        tick();
        #1 chk("rst_mdu_pre", 32'({HC_stall_if, HC_stall_id, HC_stall_ex}), 32'(3'b111));
        #2 rst_n = 1'b0;
        #1 chk("rst_mdu_now", 32'(dut_vec), 32'(0));
        tick();
        rst_n = 1'b1;
        tick();
        #1 chk("rst_mdu_post", 32'({HC_stall_if, HC_stall_id, HC_stall_ex}), 32'(3'b000));

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [25:0] e;
            rst_n        = ($urandom_range(0, 299) != 0);
            ID_rs1       = 5'($urandom_range(0, 3));
            ID_rs2       = 5'($urandom_range(0, 3));
            ID_rs1_used  = 1'($urandom_range(0, 1));
            ID_rs2_used  = 1'($urandom_range(0, 1));
            ID_vld       = ($urandom_range(0, 3) != 0);
            EX_rd        = 5'($urandom_range(0, 3));
            EX_x_rd_vld  = 1'($urandom_range(0, 1));
            EX_is_load   = 1'($urandom_range(0, 1));
            MEM_rd       = 5'($urandom_range(0, 3));
            MEM_x_rd_vld = 1'($urandom_range(0, 1));
            EX_br_taken  = ($urandom_range(0, 15) == 0);
            EX_mdu_start = ($urandom_range(0, 11) == 0);
            MDU_done     = ($urandom_range(0, 24) == 0);
            #1;
            if (!rst_n) m_reset();
            e = m_expect();
            chk("rand", 32'(dut_vec), 32'(e));
            if (rst_n) m_step(e);
            tick();
        end
        rst_n = 1'b1;

        // Continuous load-use stalling saturates the stall counter.
        do_reset();
        set_ld_use(5'd7, 5'd7);
        repeat (65530) tick();
        chk("sat_mid", 32'(HC_stall_cnt), 32'(65530));
        repeat (5) tick();
        chk("sat_top", 32'(HC_stall_cnt), 32'(16'hFFFF));
        repeat (20) tick();
        chk("sat_hold", 32'(HC_stall_cnt), 32'(16'hFFFF));
        rst_n = 1'b0;
        #1 chk("sat_rst", 32'(HC_stall_cnt), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
